// File: rtl/johnson_counter.sv
// Free-running WIDTH-bit Johnson (twisted-ring) counter with self-correction.
// The counter walks the 2*WIDTH legal states and advances on every clock edge.
// Any state outside that set, such as one left by an upset, is replaced by
// all-zeros on the next edge. The count then resumes from the start of the sequence.
module johnson_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic [WIDTH-1:0] Count_out
);

    // Current state and its successor.
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // Twisted-ring successor: a left shift with the inverted MSB fed into the LSB.
    logic [WIDTH-1:0] shift_next;

    // edge_vec[i] is set where bit i and bit i+1 differ.
    // Every legal state has at most one such boundary. The all-zeros and
    // all-ones states have none. A single run of ones that touches either
    // end of the word has exactly one.
    logic [WIDTH-2:0] edge_vec;
    logic             state_legal;

    genvar gi;

    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_edge
            assign edge_vec[gi] = count_reg[gi] ^ count_reg[gi + 1];
        end
    endgenerate

    // Zero or one boundary means the state is legal.
    // Clearing the lowest set bit must leave nothing behind.
    assign state_legal = ((edge_vec & (edge_vec - (WIDTH - 1)'(1))) == '0);

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shift_next[gi] = ~count_reg[WIDTH - 1];
            end else begin : g_upper
                assign shift_next[gi] = count_reg[gi - 1];
            end
        end
    endgenerate

    // Choose the successor: a legal state steps forward.
    // An illegal state collapses to zero in a single clock.
    always_comb begin
        count_next = '0;
        if (state_legal) begin
            count_next = shift_next;
        end
    end

    // State register.
    // Reset takes priority over both counting and correction.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign Count_out = count_reg;

endmodule

// File: tb/tb_johnson_counter.sv
// Scoreboard bench for johnson_counter. It runs a WIDTH=4 instance and a
// WIDTH=3 instance side by side from one clock.
// Expected states come from a sequence-index model. That model builds each
// state from its position in the ring and never shifts bits itself.
`timescale 1ns/1ps
module tb_johnson_counter;

    logic       Clock = 1'b0;
    logic       reset_w4;
    logic       reset_w3;
    logic [3:0] count_w4;
    logic [2:0] count_w3;

    int checks = 0;
    int errors = 0;

    // Model state: the position of each counter within its ring.
    int  idx_w4 = 0;
    int  idx_w3 = 0;
    // Set when a state was deposited by hand. The next edge must then produce zero.
    bit  bad_w4 = 1'b0;
    bit  bad_w3 = 1'b0;
    // Set once an observed value exists for a Hamming-distance comparison.
    bit  prev_ok_w4 = 1'b0;
    bit  prev_ok_w3 = 1'b0;
    logic [31:0] prev_w4;
    logic [31:0] prev_w3;
    int  step_no = 0;

    logic [31:0] exp_q_w4[$];
    logic [31:0] exp_q_w3[$];

    johnson_counter #(.WIDTH(4)) dut_w4 (
        .Clock     (Clock),
        .Reset     (reset_w4),
        .Count_out (count_w4)
    );

    johnson_counter #(.WIDTH(3)) dut_w3 (
        .Clock     (Clock),
        .Reset     (reset_w3),
        .Count_out (count_w3)
    );

    always #10 Clock = ~Clock;

    // Returns the legal state at position k of a ring of width w.
    // Positions 0..w fill with ones from the LSB.
    // Positions w+1..2w-1 then clear bits from the LSB upward.
    function automatic logic [31:0] seq_val(input int w, input int k);
        logic [31:0] ones;
        logic [31:0] one;
        one  = 32'd1;
        ones = (one << w) - one;
        if (k <= w) begin
            return (one << k) - one;
        end
        return (ones << (k - w)) & ones;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle.
    // Drive the resets and push the model's expected states before the edge.
    // After the edge, pop the expected states and compare them with the outputs.
    task automatic step(input logic r4, input logic r3);
        logic [31:0] exp4;
        logic [31:0] exp3;
        logic [31:0] got4;
        logic [31:0] got3;
        bit          seq4;
        bit          seq3;
        reset_w4 = r4;
        reset_w3 = r3;
        seq4 = !r4 && !bad_w4 && prev_ok_w4;
        seq3 = !r3 && !bad_w3 && prev_ok_w3;
        if (r4 || bad_w4) idx_w4 = 0; else idx_w4 = (idx_w4 + 1) % 8;
        if (r3 || bad_w3) idx_w3 = 0; else idx_w3 = (idx_w3 + 1) % 6;
        bad_w4 = 1'b0;
        bad_w3 = 1'b0;
        exp_q_w4.push_back(seq_val(4, idx_w4));
        exp_q_w3.push_back(seq_val(3, idx_w3));
        @(posedge Clock);
        #1;
        step_no++;
        got4 = {28'd0, count_w4};
        got3 = {29'd0, count_w3};
        exp4 = exp_q_w4.pop_front();
        exp3 = exp_q_w3.pop_front();
        $display("step %0d: rst4=%b w4=%b (exp %b)  rst3=%b w3=%b (exp %b)",
                 step_no, r4, count_w4, exp4[3:0], r3, count_w3, exp3[2:0]);
        check_val($sformatf("w4_state step%0d", step_no), got4, exp4);
        check_val($sformatf("w3_state step%0d", step_no), got3, exp3);
        if (seq4) check_val($sformatf("w4_hamming step%0d", step_no), 32'($countones(prev_w4 ^ got4)), 32'd1);
        if (seq3) check_val($sformatf("w3_hamming step%0d", step_no), 32'($countones(prev_w3 ^ got3)), 32'd1);
        prev_w4 = got4;
        prev_w3 = got3;
        prev_ok_w4 = 1'b1;
        prev_ok_w3 = 1'b1;
    endtask

    // Overwrite the WIDTH=4 state register between edges with an illegal value.
    task automatic deposit_w4(input logic [3:0] v);
        dut_w4.count_reg = v;
        bad_w4 = 1'b1;
        prev_ok_w4 = 1'b0;
        $display("deposit w4=%b", v);
    endtask

    // Overwrite the WIDTH=3 state register between edges with an illegal value.
    task automatic deposit_w3(input logic [2:0] v);
        dut_w3.count_reg = v;
        bad_w3 = 1'b1;
        prev_ok_w3 = 1'b0;
        $display("deposit w3=%b", v);
    endtask

    initial begin
        reset_w4 = 1'b1;
        reset_w3 = 1'b1;

        // Hold reset for three edges.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

        // Nine free-running edges.
        // WIDTH=4 completes its period of 8 and wraps to 0001.
        // WIDTH=3 shows its period of 6.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0);

        // Run WIDTH=4 up to 1110, then reset it for one edge mid-sequence.
        for (int i = 0; i < 16 && idx_w4 != 5; i++) step(1'b0, 1'b0);
        check_val("w4_reach_1110", {28'd0, count_w4}, 32'b1110);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Restart both counters from reset, then run 100 edges freely.
        step(1'b1, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0);

        // Illegal-state recovery for WIDTH=4.
        deposit_w4(4'b0101);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        deposit_w4(4'b1011);
        step(1'b0, 1'b0);
        deposit_w4(4'b0110);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Illegal-state recovery for WIDTH=3.
        deposit_w3(3'b010);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        deposit_w3(3'b101);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Reset takes priority over correction.
        deposit_w4(4'b1001);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        check_val("w4_queue_empty", 32'(exp_q_w4.size()), 32'd0);
        check_val("w3_queue_empty", 32'(exp_q_w3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
